// File: rtl/regfile_param.sv
// Parameterized 2-write / 2-read register file with optional zero register,
// optional write-to-read forwarding and a sequential soft-clear engine.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam bit          ZERO_EN  = (ZERO_REG != 0);
    localparam bit          BYP_EN   = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              fwd_ok;
    logic              wr0_ok;
    logic              wr1_ok;

    // Address 0 is read-only when it is the hardwired zero register.
    assign wr0_ok = we0 && (!ZERO_EN || (waddr0 != '0));
    assign wr1_ok = we1 && (!ZERO_EN || (waddr1 != '0));
    assign fwd_ok = BYP_EN && !clr_busy;

    // Storage, clear FSM and its status flags share one register process.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            clr_done <= 1'b0;
            if (state == ST_IDLE) begin
                // Port 1 assigned last so it wins an address collision.
                if (wr0_ok) begin
                    mem[waddr0] <= wdata0;
                end
                if (wr1_ok) begin
                    mem[waddr1] <= wdata1;
                end
                if (clr_req) begin
                    state    <= ST_CLEAR;
                    clr_idx  <= '0;
                    clr_busy <= 1'b1;
                end
            end else begin
                mem[clr_idx] <= '0;
                if (clr_idx == LAST_IDX) begin
                    state    <= ST_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b1;
                end else begin
                    clr_idx <= clr_idx + ADDR_W'(1);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              fwd,
        input logic              w0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              w1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] r;
        r = stored;
        if (fwd) begin
            if (w1 && (a1 == ra)) begin
                r = d1;
            end else if (w0 && (a0 == ra)) begin
                r = d0;
            end
        end
        if (ZERO_EN && (ra == '0)) begin
            r = '0;
        end
        return r;
    endfunction

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rdata1 = read_port(raddr1, mem[raddr1], fwd_ok,
                           we0, waddr0, wdata0, we1, waddr1, wdata1);
        rdata2 = read_port(raddr2, mem[raddr2], fwd_ok,
                           we0, waddr0, wdata0, we1, waddr1, wdata1);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (forwarding+zero reg, and neither)
// driven in lockstep and compared every cycle against an array-level model.
module tb_regfile_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we0, we1, clr_req;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic          a_busy, a_done, b_busy, b_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rd1), .rdata2(a_rd2),
        .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done)
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2),
        .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ma behaves as ZERO_REG=1, mb as ZERO_REG=0.
    logic [DW-1:0] ma [DEPTH];
    logic [DW-1:0] mb [DEPTH];
    logic          m_busy, m_done;
    int unsigned   clear_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ma[i] <= '0;
                mb[i] <= '0;
            end
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
            clear_left <= 0;
        end else if (m_busy) begin
            ma[5'(DEPTH - clear_left)] <= '0;
            mb[5'(DEPTH - clear_left)] <= '0;
            clear_left <= clear_left - 1;
            m_busy     <= (clear_left != 1);
            m_done     <= (clear_left == 1);
        end else begin
            m_done <= 1'b0;
            if (we0 && waddr0 != 0) ma[waddr0] <= wdata0;
            if (we1 && waddr1 != 0) ma[waddr1] <= wdata1;
            if (we0) mb[waddr0] <= wdata0;
            if (we1) mb[waddr1] <= wdata1;
            if (clr_req) begin
                m_busy     <= 1'b1;
                clear_left <= DEPTH;
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input bit zr, input bit byp, input logic [AW-1:0] ra);
        logic [DW-1:0] st;
        st = zr ? ma[ra] : mb[ra];
        if (zr && ra == 0) return '0;
        if (byp && !m_busy) begin
            if (we1 && waddr1 == ra) return wdata1;
            if (we0 && waddr0 == ra) return wdata0;
        end
        return st;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_rdata1", a_rd1, exp_rd(1'b1, 1'b1, raddr1));
            chk("a_rdata2", a_rd2, exp_rd(1'b1, 1'b1, raddr2));
            chk("b_rdata1", b_rd1, exp_rd(1'b0, 1'b0, raddr1));
            chk("b_rdata2", b_rd2, exp_rd(1'b0, 1'b0, raddr2));
            chk("a_clr_busy", 32'(a_busy), 32'(m_busy));
            chk("a_clr_done", 32'(a_done), 32'(m_done));
            chk("b_clr_busy", 32'(b_busy), 32'(m_busy));
            chk("b_clr_done", 32'(b_done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH / 2; i++) begin
            we0 = 1'b1; waddr0 = 5'(2 * i);     wdata0 = 32'hA500_0000 | 32'(2 * i);
            we1 = 1'b1; waddr1 = 5'(2 * i + 1); wdata1 = 32'hA500_0000 | 32'(2 * i + 1);
            tick();
        end
        quiet();
    endtask

    int busy_cnt, done_cnt;

    initial begin
        quiet();
        raddr1 = 5'd5; raddr2 = 5'd6;
        repeat (3) tick();
        chk_en = 1'b1;
        #1;
        chk("reset_rdata1", a_rd1, 32'h0);
        chk("reset_busy", 32'(a_busy), 32'h0);
        chk("reset_done", 32'(a_done), 32'h0);
        rst = 1'b1;

        // Forwarding of a single write, then stored value.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF; raddr1 = 5'd3;
        #1;
        chk("byp_same_cycle", a_rd1, 32'hDEAD_BEEF);
        chk("nobyp_same_cycle", b_rd1, 32'h0);
        tick(); quiet(); #1;
        chk("byp_next_cycle", a_rd1, 32'hDEAD_BEEF);
        chk("nobyp_next_cycle", b_rd1, 32'hDEAD_BEEF);

        // Write collision: port 1 wins.
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
        wdata0 = 32'h1; wdata1 = 32'h2; raddr2 = 5'd7;
        #1;
        chk("collide_byp", a_rd2, 32'h2);
        tick(); quiet(); #1;
        chk("collide_store_a", a_rd2, 32'h2);
        chk("collide_store_b", b_rd2, 32'h2);

        // Zero register ignores writes and forwarding.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF; raddr1 = 5'd0;
        #1;
        chk("zero_same_cycle", a_rd1, 32'h0);
        tick(); quiet(); #1;
        chk("zero_after", a_rd1, 32'h0);
        chk("nozero_after", b_rd1, 32'hFFFF);

        // No-bypass instance shows old value during the write cycle.
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h11; raddr1 = 5'd4;
        tick(); quiet();
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h55;
        #1;
        chk("nobyp_old", b_rd1, 32'h11);
        tick(); quiet(); #1;
        chk("nobyp_new", b_rd1, 32'h55);

        // Full soft clear with a write and a second request during the clear.
        fill();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (a_busy) busy_cnt++;
            if (a_done) done_cnt++;
            we0 = (n == 5); waddr0 = 5'd2; wdata0 = 32'hBAD0_BAD0;
            clr_req = (n == 10);
            tick();
        end
        quiet();
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clear_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = 5'(i);
            #1;
            chk("cleared_a", a_rd1, 32'h0);
            chk("cleared_b", b_rd1, 32'h0);
        end

        // Reset in the middle of a clear.
        fill();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        raddr1 = 5'd20; raddr2 = 5'd31;
        #1;
        chk("pre_reset_mid_clear", b_rd1, 32'hA500_0014);
        rst = 1'b0;
        #1;
        chk("rst_abort_busy", 32'(a_busy), 32'h0);
        chk("rst_abort_rd1", a_rd1, 32'h0);
        chk("rst_abort_rd2", b_rd2, 32'h0);
        tick();
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1234; raddr1 = 5'd9;
        tick(); quiet(); #1;
        chk("write_after_reset", b_rd1, 32'h1234);

        // Randomized traffic with occasional clears and async resets.
        for (int n = 0; n < 3000; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            waddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr1 = ($urandom_range(0, 1) != 0) ? waddr0 : 5'($urandom);
            raddr2 = ($urandom_range(0, 1) != 0) ? waddr1 : 5'($urandom);
            wdata0 = $urandom;
            wdata1 = $urandom;
            clr_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
            tick();
        end
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each register entry in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning 1 = entry 0 hardwired to zero, 0 = entry 0 is an ordinary register.
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset (asserted when 0).
REQ-007 SHALL have ports we0, we1  input  1 each  write enables, write ports 0 and 1.
REQ-008 SHALL have ports waddr0, waddr1  input  ADDR_W each  write addresses.
REQ-009 SHALL have ports wdata0, wdata1  input  DATA_W each  write data.
REQ-010 SHALL have ports raddr1, raddr2  input  ADDR_W each  read addresses.
REQ-011 SHALL have ports rdata1, rdata2  output  DATA_W each  combinational read data.
REQ-012 SHALL have port clr_req  input  1  soft-clear request, sampled on rising clk.
REQ-013 SHALL have port clr_busy  output  1  high while soft-clear is in progress.
REQ-014 SHALL have port clr_done  output  1  one-cycle pulse on soft-clear completion.

Function
REQ-015 SHALL write wdataN into entry waddrN on rising clk when weN=1 and clr_busy=0.
REQ-016 SHALL, when we0=we1=1 and waddr0==waddr1, store wdata1 only (port 1 wins).
REQ-017 SHALL, with ZERO_REG=1, ignore every write to address 0 and return 0 for every read of address 0, bypass included.
REQ-018 SHALL drive rdataK combinationally from entry raddrK with no clock latency.
REQ-019 SHALL, with BYPASS=1 and clr_busy=0, drive rdataK = wdata1 if we1=1 and waddr1==raddrK, else wdata0 if we0=1 and waddr0==raddrK, else stored value.
REQ-020 SHALL, with BYPASS=0, return the stored value only; new data becomes visible the cycle after the write edge.
REQ-021 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-022 SHALL, in IDLE, on rising clk with clr_req=1, move to CLEAR with clear index = 0.
REQ-023 SHALL, in CLEAR, zero the entry at clear index each cycle and increment the index by 1.
REQ-024 SHALL, in CLEAR, on the edge that zeroes entry DEPTH-1, return to IDLE and assert clr_done for exactly the next cycle.
REQ-025 SHALL take DEPTH cycles to clear, from the first CLEAR edge to the last.
REQ-026 SHALL drive clr_busy = 1 exactly while the FSM is in CLEAR.
REQ-027 SHALL, while clr_busy=1, ignore we0/we1, apply no bypass, and ignore clr_req.
REQ-028 SHALL, while clr_busy=1, let reads return current array contents: 0 for entries already cleared, old values otherwise.
REQ-029 SHALL, when clr_req=1 on the same edge as writes in IDLE, perform those writes and then start CLEAR on that edge.
REQ-030 SHALL size the clear index ADDR_W bits wide and SHALL NOT wrap past DEPTH-1.

Reset
REQ-031 SHALL, while rst=0 and without waiting for clk, set all DEPTH entries to 0, FSM to IDLE, clear index to 0, clr_busy=0 and clr_done=0.
REQ-032 SHALL, on rst asserted mid-CLEAR, abort the clear immediately and apply the full reset state.
REQ-033 SHALL accept writes on the first rising clk after rst returns to 1.

Verification
REQ-034 SHALL verify: reset, then we0=1 waddr0=3 wdata0=0xDEADBEEF, raddr1=3 -> rdata1=0xDEADBEEF in the same cycle (BYPASS=1); stored value visible on the next cycle.
REQ-035 SHALL verify: we0=we1=1, both addresses 7, wdata0=0x1, wdata1=0x2 -> entry 7 = 0x2; rdata2 with raddr2=7 = 0x2 in the write cycle.
REQ-036 SHALL verify: write 0xFFFF to address 0 with ZERO_REG=1 -> rdata1 = 0 in the write cycle and afterwards.
REQ-037 SHALL verify: fill all 32 entries, pulse clr_req -> clr_busy high for 32 cycles, one-cycle clr_done pulse, all entries read 0, and a we0 issued during the clear has no effect.
REQ-038 SHALL verify: rst=0 at clear index 10 -> clr_busy=0 immediately and all entries 0; a write after release succeeds.
REQ-039 SHALL verify: BYPASS=0, write 0x55 to entry 4 with raddr1=4 -> rdata1 returns the old value in the write cycle and 0x55 on the next cycle.
